// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: writeback source, branch class and the
// control word that travels from control_unit down the pipeline.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  // Class of brOp[4:3]; brOp[2:0] carries func3 for conditional branches.
  typedef enum logic [1:0] {
    BRC_NONE = 2'b00,
    BRC_JUMP = 2'b01,
    BRC_COND = 2'b10
  } br_class_e;

  typedef struct packed {
    logic       ruWr;
    logic       aluASrc;
    logic       aluBSrc;
    logic [4:0] brOp;
    logic [3:0] aluOp;
    logic       dmWr;
    logic [2:0] dmCtrl;
    wb_src_e    ruDataWrSrc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(0);

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the instruction in EX is a load whose rd is read by
// the instruction in ID. Both sources compared regardless of use.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_ruWr,
  input  logic [1:0] ex_ruDataWrSrc,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  assign load_use = ex_valid & ex_ruWr & (ex_ruDataWrSrc == WB_MEM) &
                    (ex_rd != 5'd0) & id_valid &
                    ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush,
// downstream hold and saturating debug counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_ruWr,
  input  logic            id_aluASrc,
  input  logic            id_aluBSrc,
  input  logic [4:0]      id_brOp,
  input  logic [3:0]      id_aluOp,
  input  logic            id_dmWr,
  input  logic [2:0]      id_dmCtrl,
  input  logic [1:0]      id_ruDataWrSrc,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            ex_flush,
  input  logic            ext_stall,
  output logic            ex_valid,
  output logic            ex_ruWr,
  output logic            ex_aluASrc,
  output logic            ex_aluBSrc,
  output logic [4:0]      ex_brOp,
  output logic [3:0]      ex_aluOp,
  output logic            ex_dmWr,
  output logic [2:0]      ex_dmCtrl,
  output logic [1:0]      ex_ruDataWrSrc,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            id_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  stage_t q, d;
  logic   load_use, bubble, load;

  hazard_detect u_hazard (
    .ex_valid       (q.valid),
    .ex_ruWr        (q.ctrl.ruWr),
    .ex_ruDataWrSrc (q.ctrl.ruDataWrSrc),
    .ex_rd          (q.rd),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .load_use       (load_use)
  );

  // Gated by rst_n so the stall stays low while the core is held in reset.
  assign id_stall = rst_n & ~ex_flush & (ext_stall | load_use);

  // Flush wins over hold; hold wins over load-use.
  assign bubble = ex_flush | (~ext_stall & load_use);
  assign load   = ex_flush | ~ext_stall;

  always_comb begin
    d.valid            = id_valid;
    d.ctrl.ruWr        = id_ruWr;
    d.ctrl.aluASrc     = id_aluASrc;
    d.ctrl.aluBSrc     = id_aluBSrc;
    d.ctrl.brOp        = id_brOp;
    d.ctrl.aluOp       = id_aluOp;
    d.ctrl.dmWr        = id_dmWr;
    d.ctrl.dmCtrl      = id_dmCtrl;
    d.ctrl.ruDataWrSrc = wb_src_e'(id_ruDataWrSrc);
    d.pc               = id_pc;
    d.rs1_data         = id_rs1_data;
    d.rs2_data         = id_rs2_data;
    d.imm              = id_imm;
    d.rs1              = id_rs1;
    d.rs2              = id_rs2;
    d.rd               = id_rd;
    if (bubble) begin
      d      = stage_t'(0);
      d.ctrl = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= stage_t'(0);
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (load) q <= d;
      if (ex_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (!ex_flush && !ext_stall && load_use && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_valid       = q.valid;
  assign ex_ruWr        = q.ctrl.ruWr;
  assign ex_aluASrc     = q.ctrl.aluASrc;
  assign ex_aluBSrc     = q.ctrl.aluBSrc;
  assign ex_brOp        = q.ctrl.brOp;
  assign ex_aluOp       = q.ctrl.aluOp;
  assign ex_dmWr        = q.ctrl.dmWr;
  assign ex_dmCtrl      = q.ctrl.dmCtrl;
  assign ex_ruDataWrSrc = q.ctrl.ruDataWrSrc;
  assign ex_pc          = q.pc;
  assign ex_rs1_data    = q.rs1_data;
  assign ex_rs2_data    = q.rs2_data;
  assign ex_imm         = q.imm;
  assign ex_rs1         = q.rs1;
  assign ex_rs2         = q.rs2;
  assign ex_rd          = q.rd;

endmodule
